// File: rtl/sci_pkg.sv
// Shared SCI protocol constants and slave FSM encoding.
// Used by the SCI master and every SCI slave so both ends agree on framing.
package sci_pkg;

    typedef enum logic [2:0] {
        SCI_IDLE  = 3'd0,
        SCI_ADDR  = 3'd1,
        SCI_WDATA = 3'd2,
        SCI_WACK  = 3'd3,
        SCI_TURN  = 3'd4,
        SCI_RDATA = 3'd5,
        SCI_DONE  = 3'd6
    } sci_state_e;

    localparam int   SCI_WNR_POS     = 0;
    localparam int   SCI_ADDR_POS    = 1;
    localparam int   SCI_TURN_LEN    = 1;
    localparam int   SCI_SACK_WR_LEN = 1;
    localparam logic SCI_WNR_WRITE   = 1'b1;
    localparam logic SCI_CS_ACTIVE   = 1'b0;

endpackage

// File: rtl/sci_shift_reg.sv
// MSB-first shift register with bit counter and programmable done flag.
// Serves both the address/data receive path and the read transmit path.
module sci_shift_reg #(
    parameter int W  = 36,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [W-1:0]  i_load_data,
    input  logic          i_shift,
    input  logic          i_sin,
    input  logic [CW-1:0] i_last_cnt,
    output logic [W-1:0]  o_data,
    output logic          o_sout,
    output logic          o_done
);

    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt;

    // Shift data in at the LSB; the counter tracks bits since clear/load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {r_data[W-2:0], i_sin};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_sout = r_data[W-1];
    assign o_done = (r_cnt == i_last_cnt);

endmodule

// File: rtl/sci_slave_regfile.sv
// Per-neuron SCI slave: deserialises write frames into a register file and
// serialises registers on read frames. Optional WR_PULSE port: SCI_SLAVE_WR_PULSE_EN.
module sci_slave_regfile
    import sci_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 5,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic                           SCI_CSN,
    input  logic                           SCI_SIN,
    inout  wire                            SCI_SOUT,
    inout  wire                            SCI_SACK,
`ifdef SCI_SLAVE_WR_PULSE_EN
    output logic [NUM_REGS-1:0]            WR_PULSE,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0] REGS
);

    // Receive holds address plus all but the last data bit; the last bit
    // comes straight from SCI_SIN so the write lands in the final bit cycle.
    localparam int SW = ADDR_WIDTH + DATA_WIDTH - 1;
    localparam int CW = $clog2(SW + 1);
    localparam int IW = $clog2(NUM_REGS);

    sci_state_e r_state;
    sci_state_e w_nxt_state;
    logic       r_wnr;
    logic       r_oe;
    logic       r_sout;
    logic       r_sack;
    logic       w_nxt_oe;
    logic       w_nxt_sout;
    logic       w_nxt_sack;

    logic          w_clr;
    logic          w_load;
    logic          w_shift;
    logic [SW-1:0] w_load_data;
    logic [CW-1:0] w_last_cnt;
    logic [SW-1:0] w_sh_data;
    logic          w_sh_sout;
    logic          w_sh_done;

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdval;
    logic                  w_waddr_ok;
    logic                  w_raddr_ok;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;

    sci_shift_reg #(
        .W  (SW),
        .CW (CW)
    ) u_shift (
        .i_clk       (CLK),
        .i_rst_n     (RSTN),
        .i_clr       (w_clr),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_shift     (w_shift),
        .i_sin       (SCI_SIN),
        .i_last_cnt  (w_last_cnt),
        .o_data      (w_sh_data),
        .o_sout      (w_sh_sout),
        .o_done      (w_sh_done)
    );

    assign w_waddr    = w_sh_data[SW-1 -: ADDR_WIDTH];
    assign w_wdata    = {w_sh_data[DATA_WIDTH-2:0], SCI_SIN};
    assign w_raddr    = w_sh_data[ADDR_WIDTH-1:0];
    assign w_waddr_ok = (32'(w_waddr) < NUM_REGS);
    assign w_raddr_ok = (32'(w_raddr) < NUM_REGS);
    assign w_rdval    = w_raddr_ok ? r_regs[w_raddr[IW-1:0]] : '0;

    // State register and captured write/read direction.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= SCI_IDLE;
            r_wnr   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if (r_state == SCI_IDLE && SCI_CSN == SCI_CS_ACTIVE)
                r_wnr <= SCI_SIN;
        end
    end

    // Next-state, shifter control and next registered line values.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_oe    = 1'b0;
        w_nxt_sout  = 1'b0;
        w_nxt_sack  = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_we        = 1'b0;
        w_last_cnt  = '0;
        w_load_data = {w_rdval[DATA_WIDTH-2:0], {ADDR_WIDTH{1'b0}}};
        unique case (r_state)
            SCI_IDLE: begin
                w_clr = 1'b1;
                if (SCI_CSN == SCI_CS_ACTIVE)
                    w_nxt_state = SCI_ADDR;
            end
            SCI_ADDR: begin
                w_last_cnt = CW'(ADDR_WIDTH - 1);
                if (SCI_CSN != SCI_CS_ACTIVE) begin
                    w_nxt_state = SCI_IDLE;
                end else begin
                    w_shift = 1'b1;
                    if (w_sh_done) begin
                        if (r_wnr == SCI_WNR_WRITE) begin
                            w_nxt_state = SCI_WDATA;
                        end else begin
                            w_nxt_state = SCI_TURN;
                            w_nxt_oe    = 1'b1;
                        end
                    end
                end
            end
            SCI_WDATA: begin
                w_last_cnt = CW'(SW);
                if (SCI_CSN != SCI_CS_ACTIVE) begin
                    w_nxt_state = SCI_IDLE;
                end else if (w_sh_done) begin
                    w_nxt_state = SCI_WACK;
                    w_we        = 1'b1;
                    w_nxt_oe    = 1'b1;
                    w_nxt_sack  = 1'b1;
                end else begin
                    w_shift = 1'b1;
                end
            end
            SCI_WACK: begin
                w_nxt_state = (SCI_CSN != SCI_CS_ACTIVE) ? SCI_IDLE : SCI_DONE;
            end
            SCI_TURN: begin
                if (SCI_CSN != SCI_CS_ACTIVE) begin
                    w_nxt_state = SCI_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_nxt_state = SCI_RDATA;
                    w_nxt_oe    = 1'b1;
                    w_nxt_sack  = 1'b1;
                    w_nxt_sout  = w_rdval[DATA_WIDTH-1];
                end
            end
            SCI_RDATA: begin
                w_last_cnt = CW'(DATA_WIDTH - 1);
                if (SCI_CSN != SCI_CS_ACTIVE) begin
                    w_nxt_state = SCI_IDLE;
                end else if (w_sh_done) begin
                    w_nxt_state = SCI_DONE;
                end else begin
                    w_shift    = 1'b1;
                    w_nxt_oe   = 1'b1;
                    w_nxt_sack = 1'b1;
                    w_nxt_sout = w_sh_sout;
                end
            end
            SCI_DONE: begin
                if (SCI_CSN != SCI_CS_ACTIVE)
                    w_nxt_state = SCI_IDLE;
            end
            default: begin
                w_nxt_state = SCI_IDLE;
            end
        endcase
    end

    // Registered line drivers so nothing reaches the pins combinationally.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_oe   <= 1'b0;
            r_sout <= 1'b0;
            r_sack <= 1'b0;
        end else begin
            r_oe   <= w_nxt_oe;
            r_sout <= w_nxt_sout;
            r_sack <= w_nxt_sack;
        end
    end

    // Register file; out-of-range writes are dropped.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= RESET_VALUE;
        end else if (w_we && w_waddr_ok) begin
            r_regs[w_waddr[IW-1:0]] <= w_wdata;
        end
    end

`ifdef SCI_SLAVE_WR_PULSE_EN
    logic [NUM_REGS-1:0] r_wr_pulse;

    // One-cycle strobe aligned with the write-acknowledge cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_we && w_waddr_ok)
                r_wr_pulse[w_waddr[IW-1:0]] <= 1'b1;
        end
    end

    assign WR_PULSE = r_wr_pulse;
`endif

    assign REGS     = r_regs;
    assign SCI_SOUT = r_oe ? r_sout : 1'bz;
    assign SCI_SACK = r_oe ? r_sack : 1'bz;

endmodule

// File: doc/sci_slave_regfile.md
Name: sci_slave_regfile

Overview:
- Per-neuron Serial Configuration Interface (SCI) slave. It is the downstream consumer of the SCI frames produced by the WB2SCI bridge's SCI master.
- Deserialises write frames into a local register file and serialises register contents back on read frames.
- One instance per HL/OL neuron, each selected by its own chip-select line.
- The register file outputs feed the neuron datapath (weights, bias, config).

Parameters:
- ADDR_WIDTH, 5, SCI address bits per frame (5 for HL neurons, 4 for OL neurons).
- DATA_WIDTH, 32, register and frame data width.
- NUM_REGS, 16, implemented registers; must be ≤ 2**ADDR_WIDTH.
- RESET_VALUE, 0, reset value of every register.

Ports:
- CLK  input  1  system clock; SCI is synchronous to CLK.
- RSTN  input  1  reset, asynchronous, active-low.
- SCI_CSN  input  1  chip-select from master, active-low.
- SCI_SIN  input  1  serial data from master (master SCI_SOUT).
- SCI_SOUT  inout  1  serial read data to master; high-Z unless this slave is driving.
- SCI_SACK  inout  1  acknowledge to master; high-Z unless this slave is driving.
- REGS  output  NUM_REGS*DATA_WIDTH  flattened register file; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (RSTN low, asynchronous):
  - all registers = RESET_VALUE; state = IDLE; shift counters = 0.
  - SCI_SOUT and SCI_SACK drive enables = 0 (high-Z).
- Frame format, MSB first, one bit per CLK. Cycle 0 is the first cycle SCI_CSN is sampled low.
  - cycle 0: WNR bit (1 = write, 0 = read).
  - cycles 1..ADDR_WIDTH: address.
  - Write, cycles ADDR_WIDTH+1..ADDR_WIDTH+DATA_WIDTH: data bits.
  - Write, cycle ADDR_WIDTH+DATA_WIDTH+1:
    - register updated (visible on REGS this cycle).
    - slave drives SCI_SACK=1 for exactly this one cycle.
  - Read, cycle ADDR_WIDTH+1: turnaround.
    - slave latches the selected register into its shift register.
    - drives SCI_SOUT=0, SCI_SACK=0.
  - Read, cycles ADDR_WIDTH+2..ADDR_WIDTH+DATA_WIDTH+1:
    - slave drives SCI_SOUT = data bit, MSB first.
    - SCI_SACK=1 on every one of these bit cycles.
- FSM states:
  - IDLE: wait for CSN low; capture WNR.
  - ADDR: shift address.
  - WDATA: shift write data.
  - WACK: single write-acknowledge cycle.
  - TURN: read turnaround.
  - RDATA: shift out read data.
  - DONE: wait for CSN high.
- Transitions:
  - IDLE→ADDR on CSN low.
  - ADDR→WDATA or ADDR→TURN after ADDR_WIDTH bits, selected by WNR.
  - WDATA→WACK after DATA_WIDTH bits; WACK→DONE.
  - TURN→RDATA; RDATA→DONE after DATA_WIDTH bits.
  - DONE→IDLE on CSN high.
- A new frame needs at least one CSN-high cycle between frames. DONE never restarts a frame while CSN stays low.
- Drive enables are active only in WACK, TURN and RDATA. Outputs are registered, so there are no combinational paths from inputs.
- Out-of-range address (≥ NUM_REGS):
  - write is discarded, but WACK is still issued.
  - read returns all zeros with the normal SACK timing.
- Abort: CSN sampled high in any non-IDLE state before completion.
  - next state IDLE; no register write.
  - drive enables deasserted in the next cycle.
- Asynchronous reset mid-frame: immediate return to reset state; any partial write is lost.
- A write and a read of the same register in consecutive frames: the read returns the newly written value.

Optional Feature:
- Macro SCI_SLAVE_WR_PULSE_EN.
- When defined:
  - adds output port WR_PULSE [NUM_REGS-1:0].
  - bit i is high for exactly the WACK cycle when reg i is written.
  - no pulse for out-of-range or aborted writes.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sci_pkg holds:
  - FSM state encoding (7 states).
  - frame-field offsets: WNR bit position, turnaround length = 1, SACK write-pulse length = 1.
  - the shared master/slave protocol constants, so the SCI master and this slave agree.
- One natural sub-module: sci_shift_reg.
  - parameterised width; load, shift-in and shift-out.
  - MSB-first, with a bit counter and a done flag.
  - instantiated for the address/data receive path and the read transmit path.

Test Plan:
- Write addr 5'h03, data 32'hDEADBEEF → REGS[3] = 32'hDEADBEEF at cycle 38; SACK high exactly in cycle 38; other registers unchanged.
- Read addr 5'h03 after the previous write → SCI_SOUT shifts 32'hDEADBEEF MSB-first in cycles 7..38; SACK high in cycles 7..38; lines high-Z from cycle 39 on.
- Write addr 5'h1F (≥ NUM_REGS=16), data 32'h12345678 → no REGS change; SACK pulse still in cycle 38; a subsequent read of 5'h1F returns 32'h0.
- Abort: raise CSN in cycle 20 of a write to addr 2 → REGS[2] unchanged, no SACK, state IDLE; the next full frame completes normally.
- Assert RSTN low asynchronously mid-read (cycle 15) → SOUT/SACK high-Z immediately; all REGS = RESET_VALUE; a frame after reset release works.
- Two slaves on a shared SOUT/SACK wire, only CSN[1] low → only slave 1 drives; the wire is never contended (no X); with SCI_SLAVE_WR_PULSE_EN, WR_PULSE[3] is high one cycle on write to reg 3.
